data_memory_interface: RTL and testbench

DATA_MEMORY_INTERFACE -- requirements
Module: data_memory_interface

---
 rtl/data_memory_interface_pkg.sv | 31 +++
 rtl/data_memory_interface_if.sv | 20 ++
 rtl/data_memory_interface_data_lane_aligner.sv | 45 ++++
 rtl/data_memory_interface.sv | 107 ++++++++++
 tb/tb_data_memory_interface.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/data_memory_interface_pkg.sv
// rtl/data_memory_interface_pkg.sv - load/store format encodings, FSM states and legality check
package data_memory_interface_pkg;

  typedef enum logic [2:0] {
    FMT_B  = 3'b000,
    FMT_H  = 3'b001,
    FMT_W  = 3'b010,
    FMT_BU = 3'b100,
    FMT_HU = 3'b101
  } format_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_DONE
  } state_e;

  // Unsigned formats exist only for loads; halfwords need even, words need 4-byte alignment.
  function automatic logic access_legal(input logic [2:0] fmt, input logic [1:0] offset,
                                        input logic is_store);
    case (fmt)
      FMT_B:   return 1'b1;
      FMT_BU:  return !is_store;
      FMT_H:   return !offset[0];
      FMT_HU:  return !is_store && !offset[0];
      FMT_W:   return offset == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_interface_if.sv
// rtl/data_memory_interface_if.sv - word-addressed memory request/response bus
interface data_memory_interface_if;
  logic        bus_valid;
  logic        bus_write;
  logic [31:0] bus_address;
  logic [3:0]  bus_byte_enable;
  logic [31:0] bus_write_data;
  logic        bus_ready;
  logic [31:0] bus_read_data;

  modport master (
    output bus_valid, bus_write, bus_address, bus_byte_enable, bus_write_data,
    input  bus_ready, bus_read_data
  );

  modport slave (
    input  bus_valid, bus_write, bus_address, bus_byte_enable, bus_write_data,
    output bus_ready, bus_read_data
  );
endinterface

// File: rtl/data_memory_interface_data_lane_aligner.sv
// rtl/data_memory_interface_data_lane_aligner.sv - byte-lane enables, store replication, load extraction
module data_lane_aligner
  import data_memory_interface_pkg::*;
(
  input  logic [2:0]  format,
  input  logic [1:0]  offset,
  input  logic [31:0] write_data,
  input  logic [31:0] read_data,
  output logic [3:0]  byte_enable,
  output logic [31:0] lane_write_data,
  output logic [31:0] load_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = 8'(read_data >> {offset, 3'b000});
  assign half_lane = 16'(read_data >> {offset[1], 4'b0000});

  always_comb begin
    byte_enable     = 4'b0000;
    lane_write_data = write_data;
    load_data       = read_data;
    case (format)
      FMT_B, FMT_BU: begin
        byte_enable     = 4'b0001 << offset;
        lane_write_data = {4{write_data[7:0]}};
      end
      FMT_H, FMT_HU: begin
        byte_enable     = 4'b0011 << {offset[1], 1'b0};
        lane_write_data = {2{write_data[15:0]}};
      end
      FMT_W: byte_enable = 4'b1111;
      default: ;
    endcase
    case (format)
      FMT_B:   load_data = {{24{byte_lane[7]}}, byte_lane};
      FMT_BU:  load_data = {24'h000000, byte_lane};
      FMT_H:   load_data = {{16{half_lane[15]}}, half_lane};
      FMT_HU:  load_data = {16'h0000, half_lane};
      default: ;
    endcase
  end

endmodule

// File: rtl/data_memory_interface.sv
// rtl/data_memory_interface.sv - core load/store unit bridging to a valid/ready memory bus with timeout
module data_memory_interface
  import data_memory_interface_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [2:0]  format,
  output logic [31:0] data_fetched,
  output logic        stall,
  output logic        access_error,
  data_memory_interface_if.master bus
);

  localparam int CW = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(WAIT_TIMEOUT - 1);

  state_e          state;
  logic [CW-1:0]   wait_count;
  logic [2:0]      fmt_q;
  logic [1:0]      off_q;
  logic            req;
  logic            legal;
  logic [2:0]      al_fmt;
  logic [1:0]      al_off;
  logic [3:0]      lane_be;
  logic [31:0]     lane_wdata;
  logic [31:0]     load_data;

  assign req   = read_enable | write_enable;
  assign legal = access_legal(format, address[1:0], write_enable);

  // Aligner sees the live request while idle and the latched one while the bus is busy.
  assign al_fmt = (state == ST_IDLE) ? format : fmt_q;
  assign al_off = (state == ST_IDLE) ? address[1:0] : off_q;

  assign stall = reset & ((state == ST_REQUEST) | ((state == ST_IDLE) & req & legal));

  data_lane_aligner u_aligner (
    .format          (al_fmt),
    .offset          (al_off),
    .write_data      (write_data),
    .read_data       (bus.bus_read_data),
    .byte_enable     (lane_be),
    .lane_write_data (lane_wdata),
    .load_data       (load_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state               <= ST_IDLE;
      wait_count          <= '0;
      fmt_q               <= 3'b000;
      off_q               <= 2'b00;
      data_fetched        <= 32'h0;
      access_error        <= 1'b0;
      bus.bus_valid       <= 1'b0;
      bus.bus_write       <= 1'b0;
      bus.bus_address     <= 32'h0;
      bus.bus_byte_enable <= 4'b0000;
      bus.bus_write_data  <= 32'h0;
    end else begin
      access_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            if (legal) begin
              state               <= ST_REQUEST;
              wait_count          <= '0;
              fmt_q               <= format;
              off_q               <= address[1:0];
              bus.bus_valid       <= 1'b1;
              bus.bus_write       <= write_enable;
              bus.bus_address     <= {address[31:2], 2'b00};
              bus.bus_byte_enable <= lane_be;
              bus.bus_write_data  <= lane_wdata;
            end else begin
              access_error <= 1'b1;
            end
          end
        end
        ST_REQUEST: begin
          if (bus.bus_ready) begin
            state         <= ST_DONE;
            bus.bus_valid <= 1'b0;
            if (!bus.bus_write) data_fetched <= load_data;
          end else if (wait_count == TIMEOUT_LAST) begin
            state         <= ST_DONE;
            bus.bus_valid <= 1'b0;
            data_fetched  <= 32'h0;
            access_error  <= 1'b1;
          end else begin
            wait_count <= wait_count + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_interface.sv
// tb/tb_data_memory_interface.sv - directed vector bench for data_memory_interface
module tb_data_memory_interface;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        read_enable = 1'b0;
  logic        write_enable = 1'b0;
  logic [31:0] address = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic [2:0]  format = 3'b000;
  logic [31:0] data_fetched;
  logic        stall;
  logic        access_error;

  int pass_cnt = 0;
  int total_cnt = 0;

  data_memory_interface_if bus_if ();

  data_memory_interface #(.WAIT_TIMEOUT(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .read_enable  (read_enable),
    .write_enable (write_enable),
    .address      (address),
    .write_data   (write_data),
    .format       (format),
    .data_fetched (data_fetched),
    .stall        (stall),
    .access_error (access_error),
    .bus          (bus_if)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        re;
    logic        we;
    logic [2:0]  fmt;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          n_stall;
    int          n_valid;
    int          n_err;
    logic [3:0]  be;
    logic [31:0] bwd;
    logic [31:0] baddr;
    logic        bw;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int stall_n, valid_n, err_n;
    logic [3:0]  be;
    logic [31:0] bwd, baddr;
    logic        bw;
    be = 4'b0; bwd = 32'h0; baddr = 32'h0; bw = 1'b0;
    @(negedge clock);
    read_enable  = v.re;
    write_enable = v.we;
    format       = v.fmt;
    address      = v.addr;
    write_data   = v.wd;
    bus_if.bus_ready     = 1'b1;
    bus_if.bus_read_data = v.rd;
    #1;
    stall_n = int'(stall);
    valid_n = 0;
    err_n   = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      read_enable  = 1'b0;
      write_enable = 1'b0;
      stall_n += int'(stall);
      valid_n += int'(bus_if.bus_valid);
      err_n   += int'(access_error);
      if (bus_if.bus_valid) begin
        be    = bus_if.bus_byte_enable;
        bwd   = bus_if.bus_write_data;
        baddr = bus_if.bus_address;
        bw    = bus_if.bus_write;
      end
    end
    check($sformatf("v%0d stall_cycles", idx), stall_n, v.n_stall);
    check($sformatf("v%0d valid_cycles", idx), valid_n, v.n_valid);
    check($sformatf("v%0d error_pulses", idx), err_n, v.n_err);
    check($sformatf("v%0d data_fetched", idx), data_fetched, v.data);
    if (v.n_valid > 0) begin
      check($sformatf("v%0d byte_enable", idx), {28'h0, be}, {28'h0, v.be});
      check($sformatf("v%0d bus_write_data", idx), bwd, v.bwd);
      check($sformatf("v%0d bus_address", idx), baddr, v.baddr);
      check($sformatf("v%0d bus_write", idx), {31'h0, bw}, {31'h0, v.bw});
    end
  endtask

  initial begin
    int k, unstable, stall_n, valid_n, err_n;

    //            re    we    fmt     addr          wd            rd            st va er be       bwd           baddr         bw    data
    vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h00000100, 32'h00000000, 32'hDEADBEEF, 2, 1, 0, 4'b1111, 32'h00000000, 32'h00000100, 1'b0, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h00000103, 32'h00000000, 32'h80FFFFFF, 2, 1, 0, 4'b1000, 32'h00000000, 32'h00000100, 1'b0, 32'hFFFFFF80};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h00000103, 32'h00000000, 32'h80FFFFFF, 2, 1, 0, 4'b1000, 32'h00000000, 32'h00000100, 1'b0, 32'h00000080};
    vecs[3]  = '{1'b1, 1'b0, 3'b001, 32'h00000102, 32'h00000000, 32'h80011234, 2, 1, 0, 4'b1100, 32'h00000000, 32'h00000100, 1'b0, 32'hFFFF8001};
    vecs[4]  = '{1'b1, 1'b0, 3'b101, 32'h00000100, 32'h00000000, 32'h8001F234, 2, 1, 0, 4'b0011, 32'h00000000, 32'h00000100, 1'b0, 32'h0000F234};
    vecs[5]  = '{1'b0, 1'b1, 3'b000, 32'h00000301, 32'h000000A5, 32'h00000000, 2, 1, 0, 4'b0010, 32'hA5A5A5A5, 32'h00000300, 1'b1, 32'h0000F234};
    vecs[6]  = '{1'b1, 1'b1, 3'b010, 32'h00000304, 32'h11223344, 32'hCAFEF00D, 2, 1, 0, 4'b1111, 32'h11223344, 32'h00000304, 1'b1, 32'h0000F234};
    vecs[7]  = '{1'b1, 1'b0, 3'b010, 32'h00000101, 32'h00000000, 32'h12345678, 0, 0, 1, 4'b0000, 32'h00000000, 32'h00000000, 1'b0, 32'h0000F234};
    vecs[8]  = '{1'b1, 1'b0, 3'b001, 32'h00000103, 32'h00000000, 32'h12345678, 0, 0, 1, 4'b0000, 32'h00000000, 32'h00000000, 1'b0, 32'h0000F234};
    vecs[9]  = '{1'b1, 1'b0, 3'b011, 32'h00000100, 32'h00000000, 32'h12345678, 0, 0, 1, 4'b0000, 32'h00000000, 32'h00000000, 1'b0, 32'h0000F234};
    vecs[10] = '{1'b0, 1'b1, 3'b100, 32'h00000300, 32'h000000FF, 32'h12345678, 0, 0, 1, 4'b0000, 32'h00000000, 32'h00000000, 1'b0, 32'h0000F234};
    vecs[11] = '{1'b1, 1'b0, 3'b000, 32'h00000102, 32'h00000000, 32'h12345678, 2, 1, 0, 4'b0100, 32'h00000000, 32'h00000100, 1'b0, 32'h00000034};

    bus_if.bus_ready     = 1'b0;
    bus_if.bus_read_data = 32'h0;

    // Reset values while reset is held low.
    repeat (3) @(negedge clock);
    check("rst bus_valid", {31'h0, bus_if.bus_valid}, 32'h0);
    check("rst bus_write", {31'h0, bus_if.bus_write}, 32'h0);
    check("rst bus_address", bus_if.bus_address, 32'h0);
    check("rst byte_enable", {28'h0, bus_if.bus_byte_enable}, 32'h0);
    check("rst bus_write_data", bus_if.bus_write_data, 32'h0);
    check("rst data_fetched", data_fetched, 32'h0);
    check("rst access_error", {31'h0, access_error}, 32'h0);
    check("rst stall", {31'h0, stall}, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // SH with three wait cycles before ready.
    @(negedge clock);
    write_enable = 1'b1; format = 3'b001; address = 32'h00000202; write_data = 32'h1234ABCD;
    bus_if.bus_ready = 1'b0;
    #1;
    stall_n = int'(stall); k = 0; unstable = 0; err_n = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clock);
      write_enable = 1'b0;
      stall_n += int'(stall);
      err_n   += int'(access_error);
      if (bus_if.bus_valid) begin
        k++;
        if (bus_if.bus_write_data !== 32'hABCDABCD || bus_if.bus_byte_enable !== 4'b1100 ||
            bus_if.bus_address !== 32'h00000200 || bus_if.bus_write !== 1'b1) unstable++;
      end
      bus_if.bus_ready = (k >= 4);
    end
    check("sh valid_cycles", k, 4);
    check("sh stall_cycles", stall_n, 5);
    check("sh field_changes", unstable, 0);
    check("sh error_pulses", err_n, 0);
    check("sh data_kept", data_fetched, 32'h00000034);

    // Timeout: ready never arrives.
    @(negedge clock);
    read_enable = 1'b1; format = 3'b010; address = 32'h00000400;
    bus_if.bus_ready = 1'b0; bus_if.bus_read_data = 32'hFFFFFFFF;
    #1;
    stall_n = int'(stall); valid_n = 0; err_n = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      read_enable = 1'b0;
      stall_n += int'(stall);
      valid_n += int'(bus_if.bus_valid);
      err_n   += int'(access_error);
    end
    check("to valid_cycles", valid_n, 4);
    check("to stall_cycles", stall_n, 5);
    check("to error_pulses", err_n, 1);
    check("to data_fetched", data_fetched, 32'h0);
    check("to idle_valid", {31'h0, bus_if.bus_valid}, 32'h0);

    // Reset while a request is outstanding.
    @(negedge clock);
    read_enable = 1'b1; format = 3'b010; address = 32'h00000500;
    bus_if.bus_read_data = 32'h55555555;
    @(negedge clock);
    read_enable = 1'b0;
    check("mid bus_valid_before", {31'h0, bus_if.bus_valid}, 32'h1);
    #2 reset = 1'b0;
    #1;
    check("mid bus_valid", {31'h0, bus_if.bus_valid}, 32'h0);
    check("mid access_error", {31'h0, access_error}, 32'h0);
    check("mid stall", {31'h0, stall}, 32'h0);
    check("mid bus_address", bus_if.bus_address, 32'h0);
    check("mid byte_enable", {28'h0, bus_if.bus_byte_enable}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    bus_if.bus_ready = 1'b1;
    valid_n = 0; err_n = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      valid_n += int'(bus_if.bus_valid);
      err_n   += int'(access_error);
    end
    check("post_rst valid_cycles", valid_n, 0);
    check("post_rst error_pulses", err_n, 0);
    check("post_rst data_fetched", data_fetched, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
